// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: generates test-pattern frames for an RGB565 LCD frame buffer
// and pushes them into an SDRAM write FIFO, four pixels per 64-bit word.
//
// Parameters
//   H_RES      active pixels per line (multiple of 4)
//   V_RES      active lines per frame
//   GAP_CYCLES idle cycles between frames in continuous mode
//
// Ports
//   clk_50m         single clock, rising edge
//   rst             asynchronous active-high reset
//   sdram_init_done SDRAM init complete (asynchronous, synchronized internally)
//   start           one-cycle pulse that begins a frame (honoured only in IDLE)
//   continuous      1 = loop frames indefinitely
//   pattern_sel     0 colour bars, 1 gradient, 2 checker, 3 solid
//   solid_color     RGB565 value for the solid pattern
//   wr_ready        write FIFO below its almost-full level
//   wr_en           write FIFO write enable
//   wr_data         pixels x..x+3, pixel x in [15:0], pixel x+3 in [63:48]
//   busy            high while in WRITE or GAP
//   frame_done      one-cycle pulse after the last word of a frame
//   frame_cnt       16-bit count of frame_done pulses (only when the macro
//                   LCD_FRAME_WRITER_FRAME_CNT_EN is defined)

module lcd_frame_writer #(
    parameter int unsigned H_RES      = 800,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    input  logic        wr_ready,
    output logic        wr_en,
    output logic [63:0] wr_data,
    output logic        busy,
    output logic        frame_done
`ifdef LCD_FRAME_WRITER_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // x needs at least 10 bits for the gradient, y at least 6 for the checker
    localparam int unsigned X_W   = ($clog2(H_RES) > 10) ? $clog2(H_RES) : 10;
    localparam int unsigned Y_W   = ($clog2(V_RES) > 6) ? $clog2(V_RES) : 6;
    localparam int unsigned GC_W  = $clog2(GAP_CYCLES + 1) + 1;
    localparam int unsigned BAR_W = H_RES / 8;

    localparam logic [X_W-1:0]  X_LAST   = X_W'(H_RES - 4);
    localparam logic [Y_W-1:0]  Y_LAST   = Y_W'(V_RES - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic            init_meta;
    logic            init_s;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [GC_W-1:0] gap_cnt;
    logic [1:0]      pat_q;
    logic [15:0]     solid_q;
    logic [63:0]     word_c;

    // Colour of one pixel for the latched pattern
    function automatic logic [15:0] pixel(
        input logic [1:0]     pat,
        input logic [15:0]    solid,
        input logic [X_W-1:0] xp,
        input logic [Y_W-1:0] yy
    );
        logic [2:0] bar;
        bar = 3'(xp / X_W'(BAR_W));
        case (pat)
            2'd0: begin
                case (bar)
                    3'd0:    return 16'hFFFF;
                    3'd1:    return 16'hFFE0;
                    3'd2:    return 16'h07FF;
                    3'd3:    return 16'h07E0;
                    3'd4:    return 16'hF81F;
                    3'd5:    return 16'hF800;
                    3'd6:    return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1:    return {xp[9:5], xp[9:4], xp[9:5]};
            2'd2:    return (xp[5] ^ yy[5]) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    // Word for the current position: four consecutive columns
    always_comb begin
        word_c = '0;
        for (int i = 0; i < 4; i++) begin
            word_c[16*i +: 16] = pixel(pat_q, solid_q, x + X_W'(i), y);
        end
    end

    // Two-flop synchronizer for the SDRAM init flag
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            init_meta <= 1'b0;
            init_s    <= 1'b0;
        end else begin
            init_meta <= sdram_init_done;
            init_s    <= init_meta;
        end
    end

    // Frame FSM with registered outputs. The GAP state spans the cycle that
    // presents the last word plus GAP_CYCLES cycles with wr_en low, giving a
    // frame period of words + GAP_CYCLES + 1 in continuous mode.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            gap_cnt    <= '0;
            pat_q      <= '0;
            solid_q    <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && init_s) begin
                        state   <= WRITE;
                        busy    <= 1'b1;
                        x       <= '0;
                        y       <= '0;
                        pat_q   <= pattern_sel;
                        solid_q <= solid_color;
                    end
                end
                WRITE: begin
                    if (!init_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wr_ready) begin
                        wr_en   <= 1'b1;
                        wr_data <= word_c;
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y       <= '0;
                                gap_cnt <= '0;
                                if (continuous) begin
                                    state <= GAP;
                                end else begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                y <= y + Y_W'(1);
                            end
                        end else begin
                            x <= x + X_W'(4);
                        end
                    end
                end
                GAP: begin
                    if (!init_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (gap_cnt == '0) begin
                            frame_done <= 1'b1;
                        end
                        if (gap_cnt == GAP_LAST) begin
                            state   <= WRITE;
                            x       <= '0;
                            y       <= '0;
                            pat_q   <= pattern_sel;
                            solid_q <= solid_color;
                        end else begin
                            gap_cnt <= gap_cnt + GC_W'(1);
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LCD_FRAME_WRITER_FRAME_CNT_EN
    // Count completed frames, wrapping naturally at 16 bits
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Testbench for lcd_frame_writer: small frame geometry, random backpressure and
// colours, checked word by word against a pixel-rule reference model.
`timescale 1ns/1ps

module tb_lcd_frame_writer;

    localparam int unsigned H      = 128;
    localparam int unsigned V      = 40;
    localparam int unsigned G      = 5;
    localparam int unsigned WPL    = H / 4;
    localparam int unsigned WORDS  = H * V / 4;
    localparam int unsigned PERIOD = WORDS + G + 1;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        sdram_init_done;
    logic        start;
    logic        continuous;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        wr_ready;
    logic        wr_en;
    logic [63:0] wr_data;
    logic        busy;
    logic        frame_done;
`ifdef LCD_FRAME_WRITER_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    lcd_frame_writer #(
        .H_RES(H), .V_RES(V), .GAP_CYCLES(G)
    ) dut (
        .clk_50m(clk_50m),
        .rst(rst),
        .sdram_init_done(sdram_init_done),
        .start(start),
        .continuous(continuous),
        .pattern_sel(pattern_sel),
        .solid_color(solid_color),
        .wr_ready(wr_ready),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .busy(busy),
        .frame_done(frame_done)
`ifdef LCD_FRAME_WRITER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #10 clk_50m = ~clk_50m;

    int          n_cmp = 0;
    int          n_err = 0;
    int          idx, words, dones, total_dones, cyc;
    int          done_cyc[$];
    logic [1:0]  m_pat;
    logic [15:0] m_solid;
    bit          bp_en;
    logic [63:0] cap [WORDS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pixel colour straight from the pattern rules
    function automatic logic [15:0] ref_pixel(input int xp, input int yy,
                                              input logic [1:0] pat, input logic [15:0] solid);
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(xp);
        yv = 16'(yy);
        case (pat)
            2'd0: begin
                case (xp / (H / 8))
                    0:       return 16'hFFFF;
                    1:       return 16'hFFE0;
                    2:       return 16'h07FF;
                    3:       return 16'h07E0;
                    4:       return 16'hF81F;
                    5:       return 16'hF800;
                    6:       return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'd1:    return {xv[9:5], xv[9:4], xv[9:5]};
            2'd2:    return (xv[5] ^ yv[5]) ? 16'hFFFF : 16'h0000;
            default: return solid;
        endcase
    endfunction

    function automatic logic [63:0] ref_word(input int n);
        logic [63:0] w;
        int xx, yy;
        xx = (n % WPL) * 4;
        yy = n / WPL;
        for (int i = 0; i < 4; i++) w[16*i +: 16] = ref_pixel(xx + i, yy, m_pat, m_solid);
        return w;
    endfunction

    // One clock: sample after the edge, check any word, then drive wr_ready
    task automatic tick();
        @(posedge clk_50m);
        #1;
        cyc++;
        if (wr_en) begin
            chk("word", wr_data, ref_word(idx));
            cap[idx] = wr_data;
            idx = (idx + 1) % WORDS;
            words++;
        end
        if (frame_done) begin
            dones++;
            total_dones++;
            done_cyc.push_back(cyc);
        end
        wr_ready = bp_en ? ($urandom_range(99) >= 30) : 1'b1;
    endtask

    task automatic start_frame(input logic [1:0] pat, input logic [15:0] solid, input bit scramble);
        pattern_sel = pat;
        solid_color = solid;
        m_pat       = pat;
        m_solid     = solid;
        idx         = 0;
        words       = 0;
        dones       = 0;
        done_cyc.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (scramble) begin
            pattern_sel = 2'($urandom);
            solid_color = 16'($urandom);
        end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (dones < target && n < budget) begin
            tick();
            n++;
        end
        chk("frames_done", 64'(dones), 64'(target));
    endtask

    task automatic check_idle(input string tag, input int exp_words, input int exp_dones);
        repeat (20) tick();
        chk({tag, "_words"}, 64'(words), 64'(exp_words));
        chk({tag, "_dones"}, 64'(dones), 64'(exp_dones));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        rst             = 1'b1;
        sdram_init_done = 1'b0;
        start           = 1'b0;
        continuous      = 1'b0;
        pattern_sel     = 2'd0;
        solid_color     = 16'h0000;
        wr_ready        = 1'b1;
        bp_en           = 1'b0;
        idx = 0; words = 0; dones = 0; total_dones = 0; cyc = 0;
        m_pat = 2'd0; m_solid = 16'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_wr_data", wr_data, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_frame_done", 64'(frame_done), 64'(0));
        rst = 1'b0;
        repeat (3) tick();
        total_dones = 0;

        // Start is ignored before SDRAM init completes
        start_frame(2'd0, 16'h0, 1'b0);
        repeat (40) tick();
        chk("gated_words", 64'(words), 64'(0));
        chk("gated_busy", 64'(busy), 64'(0));
        sdram_init_done = 1'b1;
        repeat (4) tick();

        // Single colour-bar frame; a start coinciding with the last word is ignored
        start_frame(2'd0, 16'h0, 1'b1);
        chk("busy_write", 64'(busy), 64'(1));
        begin
            int n;
            bit pulsed;
            n = 0;
            pulsed = 1'b0;
            while (dones < 1 && n < 3 * WORDS) begin
                if (words == WORDS && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end
                tick();
                start = 1'b0;
                n++;
            end
        end
        chk("bars_word0", cap[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("bars_word_bar1", cap[4], 64'hFFE0_FFE0_FFE0_FFE0);
        check_idle("bars", WORDS, 1);

        // Backpressure: bars, then gradient, then random solid
        bp_en = 1'b1;
        start_frame(2'd0, 16'h0, 1'b1);
        wait_dones(1, 4 * WORDS);
        check_idle("bp_bars", WORDS, 1);
        start_frame(2'd1, 16'h0, 1'b1);
        wait_dones(1, 4 * WORDS);
        check_idle("bp_grad", WORDS, 1);
        start_frame(2'd3, 16'($urandom), 1'b1);
        wait_dones(1, 4 * WORDS);
        check_idle("bp_solid", WORDS, 1);
        bp_en = 1'b0;

        // Continuous checker: three frames, then stop by clearing continuous
        continuous = 1'b1;
        start_frame(2'd2, 16'h0, 1'b0);
        wait_dones(2, 3 * PERIOD);
        chk("chk_word8", cap[8], 64'hFFFF_FFFF_FFFF_FFFF);
        continuous = 1'b0;
        wait_dones(3, 2 * PERIOD);
        if (done_cyc.size() == 3) begin
            chk("period_1", 64'(done_cyc[1] - done_cyc[0]), 64'(PERIOD));
            chk("period_2", 64'(done_cyc[2] - done_cyc[1]), 64'(PERIOD));
        end else begin
            chk("period_count", 64'(done_cyc.size()), 64'(3));
        end
        check_idle("cont", 3 * WORDS, 3);

        // SDRAM init dropped mid-frame
        start_frame(2'd1, 16'h0, 1'b1);
        begin
            int n;
            n = 0;
            while (words < 100 && n < 3 * WORDS) begin
                tick();
                n++;
            end
        end
        sdram_init_done = 1'b0;
        repeat (3) tick();
        chk("abort_wr_en", 64'(wr_en), 64'(0));
        begin
            int w_abort;
            w_abort = words;
            repeat (30) tick();
            chk("abort_no_more", 64'(words), 64'(w_abort));
        end
        chk("abort_words_bound", 64'(words <= 103), 64'(1));
        chk("abort_no_done", 64'(dones), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        sdram_init_done = 1'b1;
        repeat (4) tick();

        // Reset mid-frame, then a fresh frame restarts at x=y=0
        start_frame(2'd0, 16'h0, 1'b1);
        begin
            int n;
            n = 0;
            while (words < 200 && n < 3 * WORDS) begin
                tick();
                n++;
            end
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_en", 64'(wr_en), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        rst = 1'b0;
        total_dones = 0;
        repeat (5) tick();
        chk("rst_needs_start", 64'(words), 64'(200));
        start_frame(2'd3, 16'($urandom), 1'b0);
        wait_dones(1, 3 * WORDS);
        check_idle("post_rst", WORDS, 1);

`ifdef LCD_FRAME_WRITER_FRAME_CNT_EN
        // Two continuous frames after a reset
        chk("cnt_before", 64'(frame_cnt), 64'(total_dones));
        continuous = 1'b1;
        start_frame(2'd1, 16'h0, 1'b0);
        wait_dones(2, 3 * PERIOD);
        continuous = 1'b0;
        wait_dones(3, 2 * PERIOD);
        repeat (3) tick();
        chk("frame_cnt", 64'(frame_cnt), 64'(total_dones));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 The block SHALL have parameter H_RES, default 800, meaning active pixels per line (multiple of 4).
REQ-002 The block SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles between frames in continuous mode.
REQ-004 The block SHALL have port clk_50m, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port sdram_init_done, input, 1 bit: SDRAM init complete; this input is asynchronous.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle pulse that begins a frame.
REQ-008 The block SHALL have port continuous, input, 1 bit: 1 means loop frames indefinitely.
REQ-009 The block SHALL have port pattern_sel, input, 2 bits: 0 colour bars, 1 gradient, 2 checker, 3 solid.
REQ-010 The block SHALL have port solid_color, input, 16 bits: RGB565 value used when pattern_sel is 3.
REQ-011 The block SHALL have port wr_ready, input, 1 bit: write FIFO is below its almost-full level.
REQ-012 The block SHALL have port wr_en, output, 1 bit: write FIFO write enable.
REQ-013 The block SHALL have port wr_data, output, 64 bits: four RGB565 pixels, with pixel x in bits [15:0] and pixel x+3 in bits [63:48].
REQ-014 The block SHALL have port busy, output, 1 bit: high in states WRITE and GAP.
REQ-015 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the last word of a frame.

Function
REQ-016 sdram_init_done SHALL pass through a 2-flop synchronizer; only the synchronized value (init_s) is used.
REQ-017 The FSM states SHALL be IDLE, WRITE, GAP and DONE.
REQ-018 IDLE SHALL go to WRITE when start=1 and init_s=1; start is ignored in every other state.
REQ-019 On entry to WRITE from IDLE or GAP, x and y SHALL clear to 0 and pattern_sel and solid_color SHALL be latched for the whole frame.
REQ-020 In WRITE, wr_en and wr_data SHALL be registered, and wr_en SHALL be 1 in the cycle after any cycle where state=WRITE and wr_ready=1.
REQ-021 Each asserted wr_en SHALL carry one word, after which x advances by 4; at x=H_RES-4, x wraps to 0 and y increments.
REQ-022 When wr_ready=0, x, y and wr_data SHALL hold, wr_en SHALL be 0, and no word is skipped or duplicated.
REQ-023 A frame SHALL be exactly H_RES*V_RES/4 words (96000 at defaults).
REQ-024 After the word at x=H_RES-4, y=V_RES-1: frame_done SHALL pulse in the next cycle; the FSM goes to GAP if continuous=1, otherwise to DONE.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles with wr_en=0, then return to WRITE.
REQ-026 DONE SHALL go to IDLE in one cycle.
REQ-027 Colour bars SHALL use bar index = x/(H_RES/8) with colours FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000 for bars 0 to 7.
REQ-028 The gradient pattern SHALL give each pixel the value {xp[9:5], xp[9:4], xp[9:5]}, where xp is that pixel's column.
REQ-029 The checker pattern SHALL give each pixel FFFF when xp[5]^y[5]=1, otherwise 0000.
REQ-030 If init_s falls while in WRITE or GAP, the FSM SHALL go to IDLE, wr_en SHALL be 0 from the next cycle, and frame_done SHALL NOT pulse.
REQ-031 If start and the final word coincide, start SHALL be ignored.

Reset
REQ-032 While rst=1: state=IDLE, x=y=0, wr_en=0, wr_data=0, busy=0, frame_done=0, synchronizer=0, and the GAP counter=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no further writes; after release a new start is required.

Configuration
REQ-034 The macro LCD_FRAME_WRITER_FRAME_CNT_EN SHALL control an optional frame counter.
REQ-035 With the macro defined, a 16-bit output frame_cnt SHALL count frame_done pulses, wrap from FFFF to 0000, and reset to 0.
REQ-036 Without the macro, the frame_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-037 Single frame, colour bars, wr_ready=1: start -> 96000 wr_en pulses; word 0 = 0xFFFFFFFFFFFFFFFF; word 25 (x=100) = 0xFFE0FFE0FFE0FFE0; frame_done pulses once; then IDLE.
REQ-038 Backpressure: wr_ready toggles with pseudo-random 30% low -> word count is still 96000 and the captured sequence is identical to REQ-037.
REQ-039 Continuous, checker: 3 frames -> frame_done spaced 96000+GAP_CYCLES+1 cycles apart with wr_ready=1; word 8 (x=32, y=0) = 0xFFFFFFFFFFFFFFFF.
REQ-040 Gating: start while sdram_init_done=0 -> no wr_en; sdram_init_done dropped at word 500 -> wr_en=0 within 3 cycles, no frame_done.
REQ-041 Reset at word 1000 -> wr_en=0 at once; after release plus start, the first word again has x=y=0.
REQ-042 With LCD_FRAME_WRITER_FRAME_CNT_EN: 2 continuous frames from reset -> frame_cnt = 2.
